fifo_serializer: RTL and testbench

- Downstream drain stage for the common pointer-based FIFO.
- Pops wide entries through the FIFO's `empty`/`pop`/`rdata` interface and emits each entry as a sequence of narrow beats on a val/rdy output stream, least-significant beat first.
- Sits between a wide buffering FIFO and a narrow link or port, and sustains one beat per cycle, including across entry boundaries.

---
 rtl/fifo_serializer.sv | 118 +++++++++++
 tb/tb_fifo_serializer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_serializer.sv
// rtl/fifo_serializer.sv - drains wide FIFO entries as narrow beats, least-significant beat first
//
// Purpose: pops entries through a FIFO empty/pop/rdata interface and emits each
// entry as p_num_beats beats on a val/rdy stream, one beat per cycle, with no
// bubble between back-to-back entries.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   fifo_empty      FIFO empty flag (in)
//   fifo_pop        FIFO pop strobe (out, combinational, never high while empty or in reset)
//   fifo_rdata      FIFO head entry (in, sampled only when fifo_pop=1)
//   ostream_val     beat valid (out)
//   ostream_rdy     consumer ready (in)
//   ostream_msg     current beat (out, zero when not valid)
//   busy            an entry is held and not yet fully sent (out)
//   ostream_last    final beat of an entry (out, only with FIFO_SERIALIZER_LAST_EN)
//
// Optional feature macro: FIFO_SERIALIZER_LAST_EN adds the ostream_last port.

module fifo_serializer #(
    parameter int p_entry_bits = 32,
    parameter int p_beat_bits  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fifo_empty,
    output logic                    fifo_pop,
    input  logic [p_entry_bits-1:0] fifo_rdata,
    output logic                    ostream_val,
    input  logic                    ostream_rdy,
    output logic [p_beat_bits-1:0]  ostream_msg,
    output logic                    busy
`ifdef FIFO_SERIALIZER_LAST_EN
    ,
    output logic                    ostream_last
`endif
);

    localparam int p_num_beats = p_entry_bits / p_beat_bits;
    localparam int p_cnt_bits  = (p_num_beats > 1) ? $clog2(p_num_beats) : 1;
    localparam logic [p_cnt_bits-1:0] p_last_cnt = p_cnt_bits'(p_num_beats - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [p_entry_bits-1:0] shreg_q, shreg_d;
    logic [p_cnt_bits-1:0]   cnt_q, cnt_d;

    logic sending;
    logic handshake;
    logic final_beat;

    assign sending    = (state_q == S_SEND);
    assign handshake  = sending && ostream_rdy;
    assign final_beat = (cnt_q == p_last_cnt);

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        fifo_pop = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata;
                    cnt_d    = '0;
                    state_d  = S_SEND;
                end
            end
            default: begin
                if (handshake) begin
                    if (!final_beat) begin
                        shreg_d = shreg_q >> p_beat_bits;
                        cnt_d   = cnt_q + p_cnt_bits'(1);
                    end else if (!fifo_empty) begin
                        // Reload on the final beat so consecutive entries run gap-free.
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_rdata;
                        cnt_d    = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase

        // The register update is blocked by the async reset, so a pop seen by
        // the FIFO during reset would lose an entry.
        if (rst) begin
            fifo_pop = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ostream_val = sending;
    assign busy        = sending;
    // shreg keeps the last beat after returning to IDLE; mask it off the bus.
    assign ostream_msg = sending ? shreg_q[p_beat_bits-1:0] : '0;

`ifdef FIFO_SERIALIZER_LAST_EN
    assign ostream_last = sending && final_beat;
`endif

endmodule

// File: tb/tb_fifo_serializer.sv
// tb/tb_fifo_serializer.sv - self-checking bench for fifo_serializer
module tb_fifo_serializer;

    logic        clk;
    logic        rst;

    logic        fe0, pop0, val0, rdy0, busy0;
    logic [31:0] rd0;
    logic [7:0]  msg0;
    logic        fe1, pop1, val1, rdy1, busy1;
    logic [31:0] rd1, msg1;
`ifdef FIFO_SERIALIZER_LAST_EN
    logic        last0, last1, s_last0, s_last1;
    logic        explast0[$];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] fq0[$], fq1[$];
    logic [7:0]  exp0[$];
    logic [31:0] exp1[$];
    int          n_pop0, n_rcv0, n_pop1, n_rcv1;

    logic        s_pop0, s_val0, s_busy0;
    logic [7:0]  s_msg0;
    logic        s_pop1, s_val1, s_busy1;
    logic [31:0] s_msg1;
    logic        stall0, stall1;
    logic [7:0]  stall_msg0;
    logic [31:0] stall_msg1;

    fifo_serializer #(.p_entry_bits(32), .p_beat_bits(8)) dut (
        .clk(clk), .rst(rst),
        .fifo_empty(fe0), .fifo_pop(pop0), .fifo_rdata(rd0),
        .ostream_val(val0), .ostream_rdy(rdy0), .ostream_msg(msg0),
        .busy(busy0)
`ifdef FIFO_SERIALIZER_LAST_EN
        , .ostream_last(last0)
`endif
    );

    fifo_serializer #(.p_entry_bits(32), .p_beat_bits(32)) dut1 (
        .clk(clk), .rst(rst),
        .fifo_empty(fe1), .fifo_pop(pop1), .fifo_rdata(rd1),
        .ostream_val(val1), .ostream_rdy(rdy1), .ostream_msg(msg1),
        .busy(busy1)
`ifdef FIFO_SERIALIZER_LAST_EN
        , .ostream_last(last1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        fe0 = (fq0.size() == 0);
        rd0 = fe0 ? $urandom : fq0[0];
        fe1 = (fq1.size() == 0);
        rd1 = fe1 ? $urandom : fq1[0];
    endtask

    // Reference: an entry is its four bytes, low byte first.
    task automatic push0(input logic [31:0] e);
        fq0.push_back(e);
        for (int i = 0; i < 4; i++) begin
            exp0.push_back(e[8*i +: 8]);
`ifdef FIFO_SERIALIZER_LAST_EN
            explast0.push_back(i == 3);
`endif
        end
        drive();
    endtask

    task automatic push1(input logic [31:0] e);
        fq1.push_back(e);
        exp1.push_back(e);
        drive();
    endtask

    // Reset discards the unsent beats of entries already taken from the FIFO.
    task automatic model_reset();
        repeat (n_pop0 * 4 - n_rcv0) begin
            void'(exp0.pop_front());
`ifdef FIFO_SERIALIZER_LAST_EN
            void'(explast0.pop_front());
`endif
        end
        repeat (n_pop1 - n_rcv1) void'(exp1.pop_front());
        n_pop0 = 0; n_rcv0 = 0; n_pop1 = 0; n_rcv1 = 0;
        stall0 = 1'b0; stall1 = 1'b0;
    endtask

    task automatic cycle();
        logic [7:0]  e0;
        logic [31:0] e1;
        @(negedge clk);
        s_pop0 = pop0; s_val0 = val0; s_msg0 = msg0; s_busy0 = busy0;
        s_pop1 = pop1; s_val1 = val1; s_msg1 = msg1; s_busy1 = busy1;
`ifdef FIFO_SERIALIZER_LAST_EN
        s_last0 = last0; s_last1 = last1;
`endif
        check("pop0_while_empty", 32'(s_pop0 & fe0), 0);
        check("pop1_while_empty", 32'(s_pop1 & fe1), 0);
        check("busy0_eq_val", 32'(s_busy0), 32'(s_val0));
        if (stall0) begin
            check("hold_val0", 32'(s_val0), 1);
            check("hold_msg0", 32'(s_msg0), 32'(stall_msg0));
        end
        if (stall1) begin
            check("hold_val1", 32'(s_val1), 1);
            check("hold_msg1", s_msg1, stall_msg1);
        end
        if (s_val0 && rdy0) begin
            n_rcv0++;
            check("beat0_expected", 32'(exp0.size() > 0), 1);
            if (exp0.size() > 0) begin
                e0 = exp0.pop_front();
                check("beat0", 32'(s_msg0), 32'(e0));
`ifdef FIFO_SERIALIZER_LAST_EN
                check("last0", 32'(s_last0), 32'(explast0.pop_front()));
`endif
            end
        end
        if (s_val1 && rdy1) begin
            n_rcv1++;
            check("beat1_expected", 32'(exp1.size() > 0), 1);
            if (exp1.size() > 0) begin
                e1 = exp1.pop_front();
                check("beat1", s_msg1, e1);
`ifdef FIFO_SERIALIZER_LAST_EN
                check("last1", 32'(s_last1), 1);
`endif
            end
        end
        stall0 = s_val0 & ~rdy0; stall_msg0 = s_msg0;
        stall1 = s_val1 & ~rdy1; stall_msg1 = s_msg1;
        @(posedge clk);
        #1;
        if (s_pop0) begin void'(fq0.pop_front()); n_pop0++; end
        if (s_pop1) begin void'(fq1.pop_front()); n_pop1++; end
        drive();
    endtask

    initial begin
        logic [7:0] em;
        rst = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
        n_pop0 = 0; n_rcv0 = 0; n_pop1 = 0; n_rcv1 = 0;
        stall0 = 1'b0; stall1 = 1'b0; stall_msg0 = '0; stall_msg1 = '0;
        // FIFOs non-empty during reset: pop must stay low.
        fq0.push_back(32'h11223344);
        fq1.push_back(32'h55667788);
        drive();
        repeat (2) begin
            cycle();
            check("rst_pop0", 32'(s_pop0), 0);
            check("rst_val0", 32'(s_val0), 0);
            check("rst_msg0", 32'(s_msg0), 0);
            check("rst_busy0", 32'(s_busy0), 0);
            check("rst_pop1", 32'(s_pop1), 0);
            check("rst_val1", 32'(s_val1), 0);
`ifdef FIFO_SERIALIZER_LAST_EN
            check("rst_last0", 32'(s_last0), 0);
`endif
        end
        fq0.delete(); fq1.delete();
        drive();
        rst = 1'b0;

        // Empty FIFO
        repeat (10) begin
            cycle();
            check("empty_pop", 32'(s_pop0), 0);
            check("empty_val", 32'(s_val0), 0);
            check("empty_msg", 32'(s_msg0), 0);
        end

        // Single entry
        push0(32'hDDCCBBAA);
        cycle();
        check("single_pop", 32'(s_pop0), 1);
        check("single_val_t", 32'(s_val0), 0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            em = 8'hAA + 8'(k * 17);
            check("single_val", 32'(s_val0), 1);
            check("single_msg", 32'(s_msg0), 32'(em));
            check("single_nopop", 32'(s_pop0), 0);
            check("single_busy", 32'(s_busy0), 1);
`ifdef FIFO_SERIALIZER_LAST_EN
            check("single_last", 32'(s_last0), 32'(k == 3));
`endif
        end
        cycle();
        check("single_end_val", 32'(s_val0), 0);
        check("single_end_busy", 32'(s_busy0), 0);

        // Backpressure on beat BB
        push0(32'hDDCCBBAA);
        cycle();
        check("bp_pop", 32'(s_pop0), 1);
        cycle();
        check("bp_msg_aa", 32'(s_msg0), 32'h000000AA);
        rdy0 = 1'b0;
        repeat (3) begin
            cycle();
            check("bp_val", 32'(s_val0), 1);
            check("bp_msg", 32'(s_msg0), 32'h000000BB);
            check("bp_nopop", 32'(s_pop0), 0);
        end
        rdy0 = 1'b1;
        for (int k = 1; k < 4; k++) begin
            cycle();
            em = 8'hAA + 8'(k * 17);
            check("bp_after_msg", 32'(s_msg0), 32'(em));
            check("bp_after_nopop", 32'(s_pop0), 0);
        end
        cycle();
        check("bp_end_val", 32'(s_val0), 0);

        // Back-to-back entries
        push0(32'h44332211);
        push0(32'h88776655);
        cycle();
        check("b2b_pop", 32'(s_pop0), 1);
        for (int k = 0; k < 8; k++) begin
            cycle();
            em = 8'((k + 1) * 17);
            check("b2b_val", 32'(s_val0), 1);
            check("b2b_msg", 32'(s_msg0), 32'(em));
            check("b2b_pop_at_44", 32'(s_pop0), 32'(k == 3));
        end
        cycle();
        check("b2b_end_val", 32'(s_val0), 0);

        // Reset mid-entry after AA, BB
        push0(32'hDDCCBBAA);
        cycle();
        cycle();
        cycle();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_async_val", 32'(val0), 0);
        check("rst_async_busy", 32'(busy0), 0);
        check("rst_async_msg", 32'(msg0), 0);
        push0(32'h04030201);
        cycle();
        check("rst_hold_nopop", 32'(s_pop0), 0);
        rst = 1'b0;
        cycle();
        check("rst_rel_pop", 32'(s_pop0), 1);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("rst_rel_msg", 32'(s_msg0), 32'(k + 1));
        end
        cycle();
        check("rst_rel_end_val", 32'(s_val0), 0);

        // One beat per entry
        push1(32'hCAFEF00D);
        push1(32'h12345678);
        cycle();
        check("w_pop_first", 32'(s_pop1), 1);
        check("w_val_first", 32'(s_val1), 0);
        cycle();
        check("w_msg_a", s_msg1, 32'hCAFEF00D);
        check("w_pop_nobubble", 32'(s_pop1), 1);
        cycle();
        check("w_msg_b", s_msg1, 32'h12345678);
        check("w_val_b", 32'(s_val1), 1);
        check("w_nopop_b", 32'(s_pop1), 0);
        cycle();
        check("w_end_val", 32'(s_val1), 0);

        // Randomized traffic against the reference queues
        for (int c = 0; c < 1500; c++) begin
            if (fq0.size() < 4 && $urandom_range(0, 2) == 0) push0($urandom);
            if (fq1.size() < 4 && $urandom_range(0, 2) == 0) push1($urandom);
            rdy0 = ($urandom_range(0, 3) != 0);
            rdy1 = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rdy0 = 1'b1;
        rdy1 = 1'b1;
        for (int c = 0; c < 100 && (exp0.size() != 0 || exp1.size() != 0); c++) cycle();
        check("drain0", exp0.size(), 0);
        check("drain1", exp1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
